// File: rtl/itl_pkg.sv
// Shared definitions for the interleaver frame controller: FSM state codes,
// supported link identifiers and the link_id -> frame length lookup.
package itl_pkg;

  // FSM state type and codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_FULL  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Supported link identifiers
  localparam logic [5:0] LINK_320  = 6'h20;
  localparam logic [5:0] LINK_640  = 6'h21;
  localparam logic [5:0] LINK_1280 = 6'h22;

  // Frame length plus a flag saying whether the link_id is supported
  typedef struct packed {
    logic [15:0] len;
    logic        valid;
  } len_info_t;

  // Map a link identifier to its frame length; unknown ids give valid=0
  function automatic len_info_t frame_len(input logic [5:0] id);
    len_info_t r;
    r.len   = 16'd0;
    r.valid = 1'b0;
    case (id)
      LINK_320:  begin r.len = 16'd320;  r.valid = 1'b1; end
      LINK_640:  begin r.len = 16'd640;  r.valid = 1'b1; end
      LINK_1280: begin r.len = 16'd1280; r.valid = 1'b1; end
      default:   ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/itl_len_lut.sv
// Combinational link_id -> {frame length, valid} lookup.
module itl_len_lut
  import itl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [5:0]        link_id,
  output logic [ADDR_W-1:0] len,
  output logic              len_valid
);

  len_info_t info;

  // Decode the link identifier through the shared table function
  always_comb begin
    info      = frame_len(link_id);
    len       = ADDR_W'(info.len);
    len_valid = info.valid;
  end

endmodule

// File: rtl/itl_frame_ctrl.sv
// Interleaver frame controller: fills one frame of N bits into memory with
// linear write addresses, then hands out linear read indices on request.
//
// Handshake: din_vld and request are single-cycle qualifiers sampled on the
// rising edge; there is no back-pressure. A din_vld the controller cannot
// accept (full/draining frame) is dropped and flagged in the sticky err.
// Every output is registered, so wen/ren/frame_full appear the cycle after
// the qualifying input, and dout_vld follows ren by one further cycle.
module itl_frame_ctrl
  import itl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        link_id,
  input  logic              din_vld,
  input  logic              request,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic              ren,
  output logic [ADDR_W-1:0] ridx,
  output logic              dout_vld,
  output logic              frame_full,
  output logic              busy,
  output logic              err
);

  logic [ADDR_W-1:0] lut_len;
  logic              lut_valid;

  itl_len_lut #(.ADDR_W(ADDR_W)) u_len_lut (
    .link_id   (link_id),
    .len       (lut_len),
    .len_valid (lut_valid)
  );

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] last_q, last_d;   // N-1 of the latched link
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] ridx_q, ridx_d;
  logic              dout_vld_q, dout_vld_d;
  logic              frame_full_q, frame_full_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    last_d       = last_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    ren_d        = 1'b0;
    ridx_d       = ridx_q;
    dout_vld_d   = ren_q;
    frame_full_d = frame_full_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (din_vld) begin
          if (lut_valid) begin
            last_d  = lut_len - ADDR_W'(1);
            wen_d   = 1'b1;
            waddr_d = '0;
            wcnt_d  = ADDR_W'(1);
            rcnt_d  = '0;
            state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (din_vld) begin
          wen_d   = 1'b1;
          waddr_d = wcnt_q;
          if (wcnt_q == last_q) begin
            state_d      = ST_FULL;
            frame_full_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin // ST_FULL, ST_DRAIN
        if (din_vld) err_d = 1'b1;
        if (request) begin
          ren_d   = 1'b1;
          ridx_d  = rcnt_q;
          state_d = ST_DRAIN;
          if (rcnt_q == last_q) begin
            state_d      = ST_IDLE;
            frame_full_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q + ADDR_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      last_q       <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      ren_q        <= 1'b0;
      ridx_q       <= '0;
      dout_vld_q   <= 1'b0;
      frame_full_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      last_q       <= last_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      ren_q        <= ren_d;
      ridx_q       <= ridx_d;
      dout_vld_q   <= dout_vld_d;
      frame_full_q <= frame_full_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign ren        = ren_q;
  assign ridx       = ridx_q;
  assign dout_vld   = dout_vld_q;
  assign frame_full = frame_full_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_itl_frame_ctrl.sv
// Testbench for itl_frame_ctrl: directed vector table, hand sequences for
// whole frames, and randomized traffic against a frame-level model.
module tb_itl_frame_ctrl;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    link_id;
  logic          din_vld;
  logic          request;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          ren;
  logic [AW-1:0] ridx;
  logic          dout_vld;
  logic          frame_full;
  logic          busy;
  logic          err;

  // Clock
  always #5 clk = ~clk;

  itl_frame_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .link_id    (link_id),
    .din_vld    (din_vld),
    .request    (request),
    .wen        (wen),
    .waddr      (waddr),
    .ren        (ren),
    .ridx       (ridx),
    .dout_vld   (dout_vld),
    .frame_full (frame_full),
    .busy       (busy),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model: m_len==0 means no frame in progress;
  // a frame is complete once m_wr reaches m_len, finished once m_rd does.
  int m_len, m_wr, m_rd;
  bit m_err, m_prev_ren;
  logic          e_wen, e_ren, e_dvld, e_full, e_busy, e_err;
  logic [AW-1:0] e_waddr, e_ridx;

  function automatic int len_of(input logic [5:0] id);
    if (id == 6'h20) return 320;
    if (id == 6'h21) return 640;
    if (id == 6'h22) return 1280;
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic [5:0] lid, input logic dv, input logic rq);
    e_wen = 1'b0; e_waddr = '0; e_ren = 1'b0; e_ridx = '0;
    e_dvld = r ? 1'b0 : m_prev_ren;
    if (r) begin
      m_len = 0; m_wr = 0; m_rd = 0; m_err = 1'b0;
    end else if (m_len == 0) begin
      if (dv) begin
        if (len_of(lid) != 0) begin
          m_len = len_of(lid); m_wr = 1; m_rd = 0;
          e_wen = 1'b1; e_waddr = '0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_wr < m_len) begin
      if (dv) begin
        e_wen = 1'b1; e_waddr = AW'(m_wr); m_wr++;
      end
    end else begin
      if (dv) m_err = 1'b1;
      if (rq) begin
        e_ren = 1'b1; e_ridx = AW'(m_rd); m_rd++;
        if (m_rd == m_len) m_len = 0;
      end
    end
    m_prev_ren = e_ren;
    e_full = (m_len != 0) && (m_wr == m_len);
    e_busy = (m_len != 0);
    e_err  = m_err;
  endtask

  // Scoreboard comparison; addresses are only meaningful while enabled or on reset
  task automatic compare(input string name, input logic r,
                         input logic xw, input logic [AW-1:0] xwa,
                         input logic xr, input logic [AW-1:0] xra,
                         input logic xd, input logic xf, input logic xb, input logic xe);
    logic [AW-1:0] aw, ar;
    aw = (xw || r) ? waddr : '0;
    ar = (xr || r) ? ridx  : '0;
    n_tests++;
    if ({wen, aw, ren, ar, dout_vld, frame_full, busy, err} !==
        {xw, xwa, xr, xra, xd, xf, xb, xe}) begin
      n_fail++;
      $display("FAIL %s t=%0t got wen=%0b waddr=%0d ren=%0b ridx=%0d dvld=%0b full=%0b busy=%0b err=%0b exp wen=%0b waddr=%0d ren=%0b ridx=%0d dvld=%0b full=%0b busy=%0b err=%0b",
               name, $time, wen, aw, ren, ar, dout_vld, frame_full, busy, err,
               xw, xwa, xr, xra, xd, xf, xb, xe);
    end
  endtask

  // Driver: set inputs, let one rising edge pass, sample 1 time unit later
  task automatic apply(input logic r, input logic [5:0] lid, input logic dv, input logic rq);
    rst = r; link_id = lid; din_vld = dv; request = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic r, input logic [5:0] lid, input logic dv, input logic rq);
    model_step(r, lid, dv, rq);
    apply(r, lid, dv, rq);
    compare(name, r, e_wen, e_waddr, e_ren, e_ridx, e_dvld, e_full, e_busy, e_err);
  endtask

  // Fill until the model reports a complete frame, with optional din_vld gaps
  task automatic fill(input string name, input logic [5:0] lid, input bit gaps);
    logic dv;
    for (int k = 0; k < 5000; k++) begin
      if (m_len != 0 && m_wr == m_len) break;
      dv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(name, 1'b0, lid, dv, 1'b0);
    end
    n_tests++;
    if (!(m_len != 0 && m_wr == m_len)) begin
      n_fail++;
      $display("FAIL %s_timeout frame not full got wr=%0d required len=%0d", name, m_wr, m_len);
    end
  endtask

  // Request randomly until the model reports the frame finished
  task automatic drain(input string name);
    for (int k = 0; k < 5000; k++) begin
      if (m_len == 0) break;
      cyc(name, 1'b0, 6'h20, 1'b0, 1'($urandom_range(0, 1)));
    end
    n_tests++;
    if (m_len != 0) begin
      n_fail++;
      $display("FAIL %s_timeout frame not drained got rd=%0d required len=%0d", name, m_rd, m_len);
    end
  endtask

  typedef struct {
    logic          r;
    logic [5:0]    lid;
    logic          dv, rq;
    logic          xw;
    logic [AW-1:0] xwa;
    logic          xr;
    logic [AW-1:0] xra;
    logic          xd, xf, xb, xe;
  } vec_t;

  vec_t tbl[9];
  int   pat[4];

  initial begin
    rst = 1'b1; link_id = 6'h00; din_vld = 1'b0; request = 1'b0;
    m_len = 0; m_wr = 0; m_rd = 0; m_err = 1'b0; m_prev_ren = 1'b0;

    // Directed vectors: reset, bad link, idle request, link change after latch
    tbl[0] = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 6'h05, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 6'h05, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 6'h20, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 6'h20, 1'b1, 1'b0, 1'b1, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 6'h05, 1'b1, 1'b1, 1'b1, 12'd1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 6'h05, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    apply(1'b1, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      model_step(tbl[i].r, tbl[i].lid, tbl[i].dv, tbl[i].rq);
      apply(tbl[i].r, tbl[i].lid, tbl[i].dv, tbl[i].rq);
      compare($sformatf("vec%0d", i), tbl[i].r, tbl[i].xw, tbl[i].xwa, tbl[i].xr,
              tbl[i].xra, tbl[i].xd, tbl[i].xf, tbl[i].xb, tbl[i].xe);
    end

    // 0x20 frame, consecutive writes
    fill("fill20", 6'h20, 1'b0);

    // Request bursts of 1/3/1/5 cycles separated by idle cycles
    pat[0] = 1; pat[1] = 3; pat[2] = 1; pat[3] = 5;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < pat[p]; j++) cyc("burst", 1'b0, 6'h21, 1'b0, 1'b1);
      cyc("burst_gap", 1'b0, 6'h21, 1'b0, 1'b0);
    end
    n_tests++;
    if (m_rd != 10 || busy !== 1'b1 || frame_full !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold got busy=%0b full=%0b required busy=1 full=1", busy, frame_full);
    end

    // Drain the rest, then extra requests must be ignored
    drain("drain20");
    cyc("extra_req0", 1'b0, 6'h20, 1'b0, 1'b1);
    cyc("extra_req1", 1'b0, 6'h20, 1'b0, 1'b1);

    // 0x21 frame with gaps, then two dropped writes
    cyc("rst21", 1'b1, 6'h00, 1'b0, 1'b0);
    fill("fill21", 6'h21, 1'b1);
    cyc("drop0", 1'b0, 6'h21, 1'b1, 1'b0);
    cyc("drop1", 1'b0, 6'h21, 1'b1, 1'b0);
    cyc("read_and_drop", 1'b0, 6'h21, 1'b1, 1'b1);
    drain("drain21");

    // Reset at write 100, then a clean 0x22 frame
    cyc("rst22", 1'b1, 6'h00, 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) cyc("pre_rst", 1'b0, 6'h22, 1'b1, 1'b0);
    cyc("mid_rst", 1'b1, 6'h22, 1'b1, 1'b0);
    cyc("post_rst", 1'b0, 6'h05, 1'b0, 1'b1);
    fill("fill22", 6'h22, 1'b1);
    drain("drain22");

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      logic [5:0] lid;
      int sel;
      sel = $urandom_range(0, 4);
      if (sel == 0)      lid = 6'h20;
      else if (sel == 1) lid = 6'h21;
      else if (sel == 2) lid = 6'h22;
      else if (sel == 3) lid = 6'h20;
      else               lid = 6'($urandom_range(0, 63));
      cyc("random", 1'($urandom_range(0, 299) == 0), lid,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
